rock_search_controller: RTL and testbench
=========================================

ROCK_SEARCH_CONTROLLER -- requirements
Module: rock_search_controller

Interface
REQ-001 Parameter SENSOR_W, default 8: width of each sensor input.
REQ-002 Parameter LEVEL_W, default 3: width of amplitude and frequency settings; legal range 0..2^LEVEL_W-1.
REQ-003 Parameter SETTLE_CYCLES, default 16: clocks waited after every setting change before a sample is accepted; minimum 1.
REQ-004 Parameter CALM_THRESH, default 8: stress at or below this value ends the search.
REQ-005 Parameter HYST, default 16: stress rise over best_stress that relaunches a search from HOLD.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 sample_valid  in  1  one-cycle strobe; sensor inputs valid this cycle.
REQ-009 huilVolume  in  SENSOR_W  cry volume sample.
REQ-010 hartRitme  in  SENSOR_W  heart-rate sample.
REQ-011 restart  in  1  pulse; launches a new search from the current setting.
REQ-012 mode_hold  in  1  level; freezes all state, counters and outputs.
REQ-013 A  out  LEVEL_W  rocking amplitude setting, registered.
REQ-014 F  out  LEVEL_W  rocking frequency setting, registered.
REQ-015 busy  out  1  high in SETTLE or MEASURE.
REQ-016 locked  out  1  high in HOLD.
REQ-017 best_stress  out  SENSOR_W+1  lowest stress accepted in the current search.

Function
REQ-018 Stress s = huilVolume + hartRitme, zero-extended to SENSOR_W+1 bits, no overflow; STRESS_MAX = 2^(SENSOR_W+1)-1.
REQ-019 The FSM SHALL have states IDLE, SETTLE, MEASURE, HOLD.
REQ-020 Launch (IDLE with sample_valid, HOLD relaunch, or restart): best_stress=STRESS_MAX, axis=A, dir=up, fails=0, prev=current A/F, settle counter cleared, next state SETTLE; A/F unchanged.
REQ-021 SETTLE: counter increments each clock; after exactly SETTLE_CYCLES clocks the state is MEASURE; sample_valid ignored in SETTLE.
REQ-022 MEASURE: waits for sample_valid; the decision is taken that cycle and A/F/state update on the next edge.
REQ-023 Calm: if s <= CALM_THRESH, best_stress=s, A/F unchanged, next HOLD (checked before improvement).
REQ-024 Improvement: if s < best_stress, best_stress=s, fails=0, prev=current, step selected axis by dir (+1/-1), next SETTLE.
REQ-025 Failure: if s >= best_stress, A/F restored to prev, fails+1, dir flipped; axis toggles when the failure occurs with dir=down; then one step from prev on the new axis/dir, next SETTLE.
REQ-026 After the 4th consecutive failure (both directions, both axes), A/F=prev, next HOLD; no further step.
REQ-027 A step leaving 0..2^LEVEL_W-1 SHALL leave that axis unchanged (no wrap, no saturation beyond range); the following measurement is evaluated normally.
REQ-028 HOLD: on sample_valid with s > best_stress + HYST (computed one bit wider, no overflow), relaunch per REQ-020; otherwise remain.
REQ-029 mode_hold=1 freezes every register including the settle counter; sample_valid ignored.
REQ-030 Priority: reset > restart > mode_hold > normal operation; restart while mode_hold is high still launches.
REQ-031 busy and locked are decoded from registered state, never both high.

Reset
REQ-032 On reset: state IDLE, A=0, F=0, busy=0, locked=0, best_stress=STRESS_MAX, fails=0, axis=A, dir=up, counter=0.
REQ-033 Reset asserted mid-search SHALL abort on the next edge to the REQ-032 values regardless of other inputs.

Verification (SENSOR_W=8, LEVEL_W=3, SETTLE_CYCLES=4, CALM_THRESH=10, HYST=16)
REQ-034 Reset, then sample_valid with 100+100 -> SETTLE; busy=1 from next cycle; after exactly 4 clocks MEASURE; sample 90+90 -> best_stress=180, A=1, F=0.
REQ-035 From A=1 (best 180), sample 100+100 -> A restored 1, then A=0 step down (dir flip); sample 95+95 -> A=1, axis F, F=1.
REQ-036 Four consecutive non-improving samples -> locked=1, busy=0, A/F equal last prev, best_stress unchanged.
REQ-037 In MEASURE, sample 4+5 -> locked=1 next cycle, best_stress=9; in HOLD sample 10+15 (25 <= 25) stays locked; sample 13+13 (26) -> relaunch, busy=1, best_stress=511.
REQ-038 A=7 with dir=up improving -> A stays 7 after the step; mode_hold high for 10 cycles mid-SETTLE -> counter and outputs frozen, resume completes remaining settle count.
REQ-039 reset asserted with restart and sample_valid high during MEASURE -> next cycle all outputs at REQ-032 values.

Source files
------------

// File: rtl/rock_search_controller.sv
// Rocking-setting search controller: hill-climbs the amplitude/frequency pair
// to minimise measured stress (cry volume + heart rate), locking in HOLD once
// calm or once every neighbouring step has failed to improve.
module rock_search_controller #(
    parameter int SENSOR_W      = 8,
    parameter int LEVEL_W       = 3,
    parameter int SETTLE_CYCLES = 16,
    parameter int CALM_THRESH   = 8,
    parameter int HYST          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SENSOR_W-1:0] huilVolume,
    input  logic [SENSOR_W-1:0] hartRitme,
    input  logic                restart,
    input  logic                mode_hold,
    output logic [LEVEL_W-1:0]  A,
    output logic [LEVEL_W-1:0]  F,
    output logic                busy,
    output logic                locked,
    output logic [SENSOR_W:0]   best_stress
);
    localparam int S_W = SENSOR_W + 1;
    localparam logic [S_W-1:0]     STRESS_MAX = '1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = '1;
    // Counter runs up to SETTLE_CYCLES, so size it to hold that value.
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, HOLD} state_t;

    state_t             state_q;
    logic [LEVEL_W-1:0] a_q, f_q;
    logic [LEVEL_W-1:0] prev_a_q, prev_f_q;
    logic [S_W-1:0]     best_q;
    logic [2:0]         fails_q;
    logic               axis_q;   // 0: amplitude, 1: frequency
    logic               dir_q;    // 0: up, 1: down
    logic [CNT_W-1:0]   cnt_q;

    // Saturating-free step: a move that would leave the legal range is dropped.
    function automatic logic [LEVEL_W-1:0] step_level(input logic [LEVEL_W-1:0] v,
                                                      input logic down);
        if (down)
            return (v == '0) ? v : v - LEVEL_W'(1);
        else
            return (v == LEVEL_MAX) ? v : v + LEVEL_W'(1);
    endfunction

    logic [S_W-1:0]     stress;
    logic               calm;
    logic               hyst_hit;
    logic               launch;
    logic               fail_dir;
    logic               fail_axis;
    logic [LEVEL_W-1:0] imp_a, imp_f, fail_a, fail_f;

    assign stress   = {1'b0, huilVolume} + {1'b0, hartRitme};
    // Comparisons done one bit wider so thresholds near the top cannot wrap.
    assign calm     = ({1'b0, stress} <= (S_W + 1)'(CALM_THRESH));
    assign hyst_hit = ({1'b0, stress} > ({1'b0, best_q} + (S_W + 1)'(HYST)));

    // restart launches even while frozen; otherwise IDLE/HOLD launch on a sample.
    assign launch = restart |
                    (~mode_hold & sample_valid &
                     ((state_q == IDLE) | ((state_q == HOLD) & hyst_hit)));

    // After a failure the direction flips; the axis changes once both
    // directions of the current axis have been tried.
    assign fail_dir  = ~dir_q;
    assign fail_axis = dir_q ? ~axis_q : axis_q;

    assign imp_a  = (axis_q == 1'b0)    ? step_level(a_q, dir_q)         : a_q;
    assign imp_f  = (axis_q == 1'b1)    ? step_level(f_q, dir_q)         : f_q;
    assign fail_a = (fail_axis == 1'b0) ? step_level(prev_a_q, fail_dir) : prev_a_q;
    assign fail_f = (fail_axis == 1'b1) ? step_level(prev_f_q, fail_dir) : prev_f_q;

    // Search FSM with all search state and settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            f_q      <= '0;
            prev_a_q <= '0;
            prev_f_q <= '0;
            best_q   <= STRESS_MAX;
            fails_q  <= '0;
            axis_q   <= 1'b0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (launch) begin
            state_q  <= SETTLE;
            prev_a_q <= a_q;
            prev_f_q <= f_q;
            best_q   <= STRESS_MAX;
            fails_q  <= '0;
            axis_q   <= 1'b0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (!mode_hold) begin
            unique case (state_q)
                SETTLE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST)
                        state_q <= MEASURE;
                end
                MEASURE: begin
                    if (sample_valid) begin
                        if (calm) begin
                            best_q  <= stress;
                            state_q <= HOLD;
                        end else if (stress < best_q) begin
                            best_q   <= stress;
                            fails_q  <= '0;
                            prev_a_q <= a_q;
                            prev_f_q <= f_q;
                            a_q      <= imp_a;
                            f_q      <= imp_f;
                            cnt_q    <= '0;
                            state_q  <= SETTLE;
                        end else begin
                            fails_q <= fails_q + 3'd1;
                            dir_q   <= fail_dir;
                            axis_q  <= fail_axis;
                            if (fails_q == 3'd3) begin
                                // All four neighbours failed: park on the best setting.
                                a_q     <= prev_a_q;
                                f_q     <= prev_f_q;
                                state_q <= HOLD;
                            end else begin
                                a_q     <= fail_a;
                                f_q     <= fail_f;
                                cnt_q   <= '0;
                                state_q <= SETTLE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign A           = a_q;
    assign F           = f_q;
    assign best_stress = best_q;
    assign busy        = (state_q == SETTLE) || (state_q == MEASURE);
    assign locked      = (state_q == HOLD);

endmodule

// File: tb/tb_rock_search_controller.sv
// Bench for rock_search_controller: directed stimulus, a behavioural model of
// the search checked every cycle, plus hand-computed spot values.
module tb_rock_search_controller;
    localparam int SW   = 8;
    localparam int LW   = 3;
    localparam int SC   = 4;
    localparam int CT   = 10;
    localparam int HY   = 16;
    localparam int SMAX = (1 << (SW + 1)) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_valid = 1'b0;
    logic          restart = 1'b0;
    logic          mode_hold = 1'b0;
    logic [SW-1:0] huil = '0;
    logic [SW-1:0] hart = '0;
    logic [LW-1:0] A, F;
    logic          busy, locked;
    logic [SW:0]   best_stress;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rock_search_controller #(
        .SENSOR_W(SW), .LEVEL_W(LW), .SETTLE_CYCLES(SC),
        .CALM_THRESH(CT), .HYST(HY)
    ) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .huilVolume(huil), .hartRitme(hart), .restart(restart),
        .mode_hold(mode_hold), .A(A), .F(F), .busy(busy),
        .locked(locked), .best_stress(best_stress)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the search and the four neighbour trials, in the order they are
    // attempted: A up, A down, F up, F down. A failure simply moves on to the
    // next trial; an improvement keeps trying the same one.
    localparam int P_IDLE = 0, P_SETTLE = 1, P_MEAS = 2, P_HOLD = 3;
    int m_phase, m_a, m_f, m_best, m_pa, m_pf, m_trial, m_nfail, m_left;
    bit m_valid = 1'b0;

    function automatic int moved(input int v, input int d);
        if (v + d < 0 || v + d > LMAX) return v;
        return v + d;
    endfunction

    task automatic m_try_from(input int ba, input int bf);
        int d;
        d = (m_trial % 2 == 0) ? 1 : -1;
        m_a = (m_trial < 2) ? moved(ba, d) : ba;
        m_f = (m_trial >= 2) ? moved(bf, d) : bf;
        m_left = SC;
        m_phase = P_SETTLE;
    endtask

    task automatic m_launch();
        m_best = SMAX; m_trial = 0; m_nfail = 0;
        m_pa = m_a; m_pf = m_f; m_left = SC; m_phase = P_SETTLE;
    endtask

    task automatic model_step(input bit rst, input bit rs, input bit mh, input bit sv, input int s);
        if (rst) begin
            m_phase = P_IDLE; m_a = 0; m_f = 0; m_pa = 0; m_pf = 0;
            m_best = SMAX; m_trial = 0; m_nfail = 0; m_left = 0; m_valid = 1'b1;
        end else if (rs) begin
            m_launch();
        end else if (!mh) begin
            case (m_phase)
                P_IDLE: if (sv) m_launch();
                P_SETTLE: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_MEAS;
                end
                P_MEAS: if (sv) begin
                    if (s <= CT) begin
                        m_best = s; m_phase = P_HOLD;
                    end else if (s < m_best) begin
                        m_best = s; m_nfail = 0; m_pa = m_a; m_pf = m_f;
                        m_try_from(m_a, m_f);
                    end else begin
                        m_nfail++;
                        m_trial = (m_trial + 1) % 4;
                        if (m_nfail == 4) begin
                            m_a = m_pa; m_f = m_pf; m_phase = P_HOLD;
                        end else begin
                            m_try_from(m_pa, m_pf);
                        end
                    end
                end
                default: if (sv && s > m_best + HY) m_launch();
            endcase
        end
    endtask

    // Compare process: advance the model with the inputs that were present at
    // the rising edge, then check every output on the falling edge.
    initial forever begin
        @(negedge clk);
        model_step(reset, restart, mode_hold, sample_valid, int'(huil) + int'(hart));
        if (m_valid) begin
            chk("model_A", int'(A), m_a);
            chk("model_F", int'(F), m_f);
            chk("model_busy", int'(busy), int'(m_phase == P_SETTLE || m_phase == P_MEAS));
            chk("model_locked", int'(locked), int'(m_phase == P_HOLD));
            chk("model_best", int'(best_stress), m_best);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rst, input bit rs, input bit mh, input bit sv,
                         input int h, input int r);
        @(negedge clk);
        #1;
        reset = rst; restart = rs; mode_hold = mh; sample_valid = sv;
        huil = SW'(h); hart = SW'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic samp(input int h, input int r);
        drive(1'b0, 1'b0, 1'b0, 1'b1, h, r);
        $display("sample %0d+%0d -> A=%0d F=%0d busy=%0b locked=%0b best=%0d",
                 h, r, A, F, busy, locked, best_stress);
    endtask

    task automatic expect_out(input string tag, input int ea, input int ef,
                              input int eb, input int el, input int ebest);
        chk({tag, "_A"}, int'(A), ea);
        chk({tag, "_F"}, int'(F), ef);
        chk({tag, "_busy"}, int'(busy), eb);
        chk({tag, "_locked"}, int'(locked), el);
        chk({tag, "_best"}, int'(best_stress), ebest);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        expect_out("reset", 0, 0, 0, 0, 511);

        // First search: launch, settle 4 clocks, improvements then four failures.
        samp(100, 100);
        expect_out("launch", 0, 0, 1, 0, 511);
        idle(4); samp(90, 90);
        expect_out("improve1", 1, 0, 1, 0, 180);
        idle(4); samp(85, 85);
        expect_out("improve2", 2, 0, 1, 0, 170);
        idle(4); samp(100, 100);
        expect_out("fail1", 0, 0, 1, 0, 170);
        idle(4); samp(95, 95);
        expect_out("fail2", 1, 1, 1, 0, 170);
        idle(4); samp(100, 100);
        expect_out("fail3_edge", 1, 0, 1, 0, 170);
        idle(4); samp(100, 100);
        expect_out("fail4_hold", 1, 0, 0, 1, 170);

        // Hysteresis boundary: 186 = 170+16 stays, 187 relaunches.
        samp(93, 93);
        expect_out("hyst_eq", 1, 0, 0, 1, 170);
        samp(94, 93);
        expect_out("hyst_over", 1, 0, 1, 0, 511);

        // Calm lock and relaunch around best 9.
        idle(4); samp(100, 100);
        expect_out("improve3", 2, 0, 1, 0, 200);
        idle(4); samp(4, 5);
        expect_out("calm", 2, 0, 0, 1, 9);
        samp(10, 15);
        expect_out("calm_hyst_eq", 2, 0, 0, 1, 9);
        samp(13, 13);
        expect_out("calm_relaunch", 2, 0, 1, 0, 511);

        // Climb A to the top and step past it.
        idle(4); samp(100, 100);
        idle(4); samp(99, 100);
        idle(4); samp(99, 99);
        idle(4); samp(98, 99);
        idle(4); samp(98, 98);
        expect_out("climb_A7", 7, 0, 1, 0, 196);
        idle(4); samp(97, 98);
        expect_out("top_edge", 7, 0, 1, 0, 195);

        // Freeze mid-settle with sample_valid toggling; then finish the settle.
        idle(2);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, i[0], 1, 1);
        expect_out("frozen", 7, 0, 1, 0, 195);
        idle(1);
        samp(1, 1);
        expect_out("settle_ignores", 7, 0, 1, 0, 195);
        samp(100, 100);
        expect_out("after_freeze", 6, 0, 1, 0, 195);

        // restart wins over mode_hold.
        idle(1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        expect_out("restart_hold", 6, 0, 1, 0, 511);

        // Reset wins over restart and a calm sample in MEASURE.
        idle(4);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4, 5);
        expect_out("reset_abort", 0, 0, 0, 0, 511);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
